// File: rtl/otter_mem_pkg.sv
// Shared types and constants for the memory write path.
// The byte-lane helper turns a lane index into a one-hot enable.
package otter_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } writer_state_t;

  localparam int MEM_WORDS  = 16384;
  localparam int BYTE_LANES = 4;

  function automatic logic [BYTE_LANES-1:0] lane_bit(input logic [1:0] idx);
    lane_bit = BYTE_LANES'(1) << idx;
  endfunction

endpackage

// File: rtl/memory_writer_if.sv
// Byte-stream, control and memory write-port signals of memory_writer.
// master = load controller / byte source, slave = the writer itself.
interface memory_writer_if #(
  parameter int LEN_WIDTH = 17
);
  logic                 start;
  logic [31:0]          base_addr;
  logic [LEN_WIDTH-1:0] num_bytes;
  logic                 in_valid;
  logic [7:0]           in_data;
  logic                 in_ready;
  logic                 mem_we;
  logic [31:0]          mem_addr;
  logic [31:0]          mem_din;
  logic [3:0]           mem_be;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output start, base_addr, num_bytes, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_din, mem_be, busy, done, err
  );

  modport slave (
    input  start, base_addr, num_bytes, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_din, mem_be, busy, done, err
  );
endinterface

// File: rtl/memory_writer_byte_packer.sv
// Packs accepted bytes little-endian into one word with a lane mask.
// o_word/o_mask show the word including the byte loaded this cycle.
module byte_packer
  import otter_mem_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clear,
  input  logic                    i_load,
  input  logic [7:0]              i_byte,
  output logic [8*BYTE_LANES-1:0] o_word,
  output logic [BYTE_LANES-1:0]   o_mask,
  output logic                    o_full
);

  logic [1:0]              r_lane;
  logic [8*BYTE_LANES-1:0] r_word;
  logic [BYTE_LANES-1:0]   r_mask;
  logic [8*BYTE_LANES-1:0] w_word;
  logic [BYTE_LANES-1:0]   w_mask;

  always_comb begin
    w_word = r_word;
    w_mask = r_mask;
    if (i_load) begin
      w_word[8*r_lane +: 8] = i_byte;
      w_mask                = r_mask | lane_bit(r_lane);
    end else begin
      w_word = r_word;
      w_mask = r_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane <= 2'd0;
      r_word <= '0;
      r_mask <= '0;
    end else if (i_clear) begin
      r_lane <= 2'd0;
      r_word <= '0;
      r_mask <= '0;
    end else if (i_load) begin
      r_lane <= r_lane + 2'd1;
      r_word <= w_word;
      r_mask <= w_mask;
    end
  end

  assign o_word = w_word;
  assign o_mask = w_mask;
  assign o_full = i_load && (r_lane == 2'd3);

endmodule

// File: rtl/memory_writer.sv
// Boot-loader write path: packs a byte stream into little-endian words and
// issues one synchronous word write per packed word.
module memory_writer
  import otter_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = $clog2(MEM_WORDS),
  parameter int LEN_WIDTH  = 17
) (
  input  logic            clk,
  input  logic            rst_n,
  memory_writer_if.slave  bus
);

  writer_state_t         r_state;
  logic [ADDR_WIDTH-1:0] r_word_addr;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic                  r_in_ready;
  logic                  r_mem_we;
  logic [31:0]           r_mem_addr;
  logic [31:0]           r_mem_din;
  logic [3:0]            r_mem_be;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_clear;
  logic [31:0]           w_word;
  logic [3:0]            w_mask;
  logic                  w_full;
  logic                  w_unused_addr_bits;

  assign w_accept = (r_state == LOAD) && bus.in_valid && r_in_ready;
  assign w_last   = w_accept && (r_remaining == LEN_WIDTH'(1));
  assign w_clear  = ((r_state == IDLE) && bus.start) || (r_state == WRITE);
  assign w_unused_addr_bits = ^{bus.base_addr[31:ADDR_WIDTH+2], bus.base_addr[1:0]};

  byte_packer u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_clear),
    .i_load  (w_accept),
    .i_byte  (bus.in_data),
    .o_word  (w_word),
    .o_mask  (w_mask),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_word_addr <= '0;
      r_remaining <= '0;
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_din   <= 32'd0;
      r_mem_be    <= 4'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_mem_we  <= 1'b0;
      r_mem_din <= 32'd0;
      r_mem_be  <= 4'd0;
      r_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b0;
          if (bus.start) begin
            r_word_addr <= bus.base_addr[ADDR_WIDTH+1:2];
            r_remaining <= bus.num_bytes;
            r_err       <= 1'b0;
            r_busy      <= 1'b1;
            if (bus.num_bytes == {LEN_WIDTH{1'b0}}) begin
              r_state <= DONE;
            end else begin
              r_state    <= LOAD;
              r_in_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (w_accept) begin
            r_remaining <= r_remaining - LEN_WIDTH'(1);
            // Word is committed on the edge that takes its final byte.
            if (w_full || w_last) begin
              r_state    <= WRITE;
              r_in_ready <= 1'b0;
              r_mem_we   <= 1'b1;
              r_mem_addr <= {{(30-ADDR_WIDTH){1'b0}}, r_word_addr, 2'b00};
              r_mem_din  <= w_word;
              r_mem_be   <= w_mask;
            end
          end
        end
        WRITE: begin
          if (r_remaining == {LEN_WIDTH{1'b0}}) begin
            r_state <= DONE;
          end else if (r_word_addr == {ADDR_WIDTH{1'b1}}) begin
            r_err   <= 1'b1;
            r_state <= DONE;
          end else begin
            r_word_addr <= r_word_addr + ADDR_WIDTH'(1);
            r_in_ready  <= 1'b1;
            r_state     <= LOAD;
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.mem_we   = r_mem_we;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_din  = r_mem_din;
  assign bus.mem_be   = r_mem_be;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_memory_writer.sv
// Scoreboard bench for memory_writer: directed loads push expected writes and
// done/err outcomes; a negedge monitor pops and compares them.
module tb_memory_writer;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  be;
  } wr_t;

  wr_t        exp_wr[$];
  logic       exp_done[$];
  logic [7:0] mem_model [int];
  int         last_acc_cyc;
  int         last_evt_cyc;

  memory_writer_if #(.LEN_WIDTH(17)) bus ();

  memory_writer #(.ADDR_WIDTH(14), .LEN_WIDTH(17)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: checks every write and every done pulse against the scoreboard.
  initial begin
    wr_t w;
    logic e;
    last_acc_cyc = 0;
    last_evt_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.in_valid && bus.in_ready) last_acc_cyc = cyc;
        if (bus.start && !bus.busy) last_evt_cyc = cyc;
        if (bus.mem_we) begin
          chk("we_latency", 32'(cyc), 32'(last_acc_cyc + 1));
          chk("we_in_ready", {31'd0, bus.in_ready}, 32'd0);
          chk("we_busy", {31'd0, bus.busy}, 32'd1);
          if (exp_wr.size() == 0) begin
            chk("unexpected_write", bus.mem_addr, 32'hFFFF_FFFF);
          end else begin
            w = exp_wr.pop_front();
            chk("wr_addr", bus.mem_addr, w.addr);
            chk("wr_din", bus.mem_din, w.din);
            chk("wr_be", {28'd0, bus.mem_be}, {28'd0, w.be});
          end
          for (int k = 0; k < 4; k++) begin
            if (bus.mem_be[k]) mem_model[int'(bus.mem_addr) + k] = bus.mem_din[8*k +: 8];
          end
          last_evt_cyc = cyc;
        end else begin
          chk("idle_din", bus.mem_din, 32'd0);
        end
        if (bus.done) begin
          chk("done_latency", 32'(cyc), 32'(last_evt_cyc + 2));
          chk("done_busy", {31'd0, bus.busy}, 32'd0);
          if (exp_done.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_done.pop_front();
            chk("done_err", {31'd0, bus.err}, {31'd0, e});
          end
        end
      end
    end
  end

  task automatic chk_zeros(input string tag);
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    chk({tag, "_mem_we"},   {31'd0, bus.mem_we},   32'd0);
    chk({tag, "_mem_addr"}, bus.mem_addr,          32'd0);
    chk({tag, "_mem_din"},  bus.mem_din,           32'd0);
    chk({tag, "_mem_be"},   {28'd0, bus.mem_be},   32'd0);
    chk({tag, "_busy"},     {31'd0, bus.busy},     32'd0);
    chk({tag, "_done"},     {31'd0, bus.done},     32'd0);
    chk({tag, "_err"},      {31'd0, bus.err},      32'd0);
  endtask

  task automatic start_load(input logic [31:0] base, input logic [16:0] n);
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.num_bytes = n;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    got = 1'b0;
    bus.in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("byte_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] bp_bytes [8];
    int         bp_gaps  [8];
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.base_addr = 32'd0;
    bus.num_bytes = 17'd0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'd0;
    repeat (2) @(negedge clk);
    chk_zeros("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic word
    exp_wr.push_back('{32'h0000_0100, 32'h4433_2211, 4'hF});
    exp_done.push_back(1'b0);
    start_load(32'h0000_0100, 17'd4);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    wait_done();

    // Partial tail
    exp_wr.push_back('{32'h0000_0200, 32'hA3A2_A1A0, 4'hF});
    exp_wr.push_back('{32'h0000_0204, 32'h0000_A5A4, 4'h3});
    exp_done.push_back(1'b0);
    start_load(32'h0000_0200, 17'd6);
    for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i), 0);
    wait_done();

    // Idle source gaps
    bp_bytes = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    bp_gaps  = '{0, 2, 1, 0, 3, 0, 1, 2};
    exp_wr.push_back('{32'h0000_0600, 32'h1312_1110, 4'hF});
    exp_wr.push_back('{32'h0000_0604, 32'h1716_1514, 4'hF});
    exp_done.push_back(1'b0);
    start_load(32'h0000_0600, 17'd8);
    for (int i = 0; i < 8; i++) send_byte(bp_bytes[i], bp_gaps[i]);
    wait_done();
    for (int i = 0; i < 8; i++) begin
      if (mem_model.exists(32'h600 + i)) chk("image_byte", {24'd0, mem_model[32'h600 + i]}, {24'd0, bp_bytes[i]});
      else chk("image_missing", 32'd0, 32'd1);
    end

    // Zero length
    exp_done.push_back(1'b0);
    start_load(32'h0000_0700, 17'd0);
    wait_done();

    // Start while busy is ignored
    exp_wr.push_back('{32'h0000_0300, 32'h8D7C_6B5A, 4'hF});
    exp_done.push_back(1'b0);
    start_load(32'h0000_0300, 17'd4);
    send_byte(8'h5A, 0); send_byte(8'h6B, 0);
    start_load(32'h0000_0400, 17'd0);
    send_byte(8'h7C, 0); send_byte(8'h8D, 0);
    wait_done();

    // Overflow at the top word
    exp_wr.push_back('{32'h0000_FFFC, 32'hDDCC_BBAA, 4'hF});
    exp_done.push_back(1'b1);
    start_load(32'h0000_FFFC, 17'd8);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0); send_byte(8'hDD, 0);
    wait_done();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ovf_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
      chk("ovf_err_sticky", {31'd0, bus.err}, 32'd1);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    exp_done.push_back(1'b0);
    start_load(32'h0000_0000, 17'd0);
    @(negedge clk);
    chk("err_cleared", {31'd0, bus.err}, 32'd0);
    wait_done();

    // Reset mid-load, then reload
    start_load(32'h0000_0500, 17'd4);
    send_byte(8'h01, 0); send_byte(8'h02, 0);
    #2 rst_n = 1'b0;
    #1 chk_zeros("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_wr.push_back('{32'h0000_0500, 32'h0403_0201, 4'hF});
    exp_done.push_back(1'b0);
    start_load(32'h0000_0500, 17'd4);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    wait_done();

    repeat (3) @(negedge clk);
    chk("writes_left", 32'(exp_wr.size()), 32'd0);
    chk("dones_left", 32'(exp_done.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
